// File: rtl/cpu86_icache_lane.sv
// cpu86_icache_lane
//   Instruction-cache fetch lane. Accepts tagged fetch requests, forwards the
//   address to a single memory read port through a one-entry command register,
//   and keeps the reorder tags in an in-order FIFO while reads are in flight.
//   Each returned memory word is paired with the oldest tag and presented as a
//   single-cycle beat on a channel without backpressure.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   s_axis_req_*               fetch request in (address in tdata, tag in tuser)
//   m_axis_cmd_*               memory read command out (address)
//   s_axis_rd_*                memory read data in, returned in command order
//   m_axis_data_*              tagged result out, one-cycle pulse
//   err                        sticky: read data arrived with nothing in flight
module cpu86_icache_lane #(
    parameter int TDATA_WIDTH     = 32,
    parameter int TUSER_WIDTH     = 4,
    parameter int ADDR_WIDTH      = 20,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_axis_req_tvalid,
    output logic                   s_axis_req_tready,
    input  logic [ADDR_WIDTH-1:0]  s_axis_req_tdata,
    input  logic [TUSER_WIDTH-1:0] s_axis_req_tuser,
    output logic                   m_axis_cmd_tvalid,
    input  logic                   m_axis_cmd_tready,
    output logic [ADDR_WIDTH-1:0]  m_axis_cmd_tdata,
    input  logic                   s_axis_rd_tvalid,
    input  logic [TDATA_WIDTH-1:0] s_axis_rd_tdata,
    output logic                   m_axis_data_tvalid,
    output logic [TDATA_WIDTH-1:0] m_axis_data_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_data_tuser,
    output logic                   err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [TUSER_WIDTH-1:0] tag_mem_q [MAX_OUTSTANDING];
    logic                   cmd_valid_q;
    logic [ADDR_WIDTH-1:0]  cmd_addr_q;
    logic                   out_valid_q;
    logic [TDATA_WIDTH-1:0] out_data_q;
    logic [TUSER_WIDTH-1:0] out_tag_q;
    logic                   err_q;

    logic accept;
    logic pop;

    // The command register can take a new address when it is empty or being
    // drained this cycle; cnt also covers a command not yet sent, so the tag
    // FIFO can never be pushed past full.
    assign s_axis_req_tready = (~cmd_valid_q | m_axis_cmd_tready) &
                               (cnt_q != CNT_W'(MAX_OUTSTANDING));
    assign accept = s_axis_req_tvalid & s_axis_req_tready;
    // Stray read data with nothing outstanding must not underflow the FIFO.
    assign pop    = s_axis_rd_tvalid & (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_q[i] <= '0;
            end
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            cnt_q <= cnt_d;

            if (accept) begin
                cmd_valid_q         <= 1'b1;
                cmd_addr_q          <= s_axis_req_tdata;
                tag_mem_q[wr_ptr_q] <= s_axis_req_tuser;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end else if (m_axis_cmd_tready) begin
                cmd_valid_q <= 1'b0;
            end

            out_valid_q <= pop;
            if (pop) begin
                out_data_q <= s_axis_rd_tdata;
                out_tag_q  <= tag_mem_q[rd_ptr_q];
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            end

            if (s_axis_rd_tvalid && cnt_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    assign m_axis_cmd_tvalid  = cmd_valid_q;
    assign m_axis_cmd_tdata   = cmd_addr_q;
    assign m_axis_data_tvalid = out_valid_q;
    assign m_axis_data_tdata  = out_data_q;
    assign m_axis_data_tuser  = out_tag_q;
    assign err                = err_q;

endmodule

// File: tb/tb_cpu86_icache_lane.sv
// Testbench for cpu86_icache_lane: directed vectors, expected result beats
// queued at the moment the bench drives read data, popped by a monitor.
module tb_cpu86_icache_lane;

    localparam int DW = 32;
    localparam int UW = 4;
    localparam int AW = 20;
    localparam int MO = 4;

    logic          clk;
    logic          reset;
    logic          s_axis_req_tvalid;
    logic          s_axis_req_tready;
    logic [AW-1:0] s_axis_req_tdata;
    logic [UW-1:0] s_axis_req_tuser;
    logic          m_axis_cmd_tvalid;
    logic          m_axis_cmd_tready;
    logic [AW-1:0] m_axis_cmd_tdata;
    logic          s_axis_rd_tvalid;
    logic [DW-1:0] s_axis_rd_tdata;
    logic          m_axis_data_tvalid;
    logic [DW-1:0] m_axis_data_tdata;
    logic [UW-1:0] m_axis_data_tuser;
    logic          err;

    cpu86_icache_lane #(
        .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_req_tvalid (s_axis_req_tvalid),
        .s_axis_req_tready (s_axis_req_tready),
        .s_axis_req_tdata  (s_axis_req_tdata),
        .s_axis_req_tuser  (s_axis_req_tuser),
        .m_axis_cmd_tvalid (m_axis_cmd_tvalid),
        .m_axis_cmd_tready (m_axis_cmd_tready),
        .m_axis_cmd_tdata  (m_axis_cmd_tdata),
        .s_axis_rd_tvalid  (s_axis_rd_tvalid),
        .s_axis_rd_tdata   (s_axis_rd_tdata),
        .m_axis_data_tvalid(m_axis_data_tvalid),
        .m_axis_data_tdata (m_axis_data_tdata),
        .m_axis_data_tuser (m_axis_data_tuser),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DW+UW-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every presented result beat must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && m_axis_data_tvalid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat actual=%0h/%0h required=none at %0t",
                         m_axis_data_tdata, m_axis_data_tuser, $time);
            end else begin
                logic [DW+UW-1:0] e;
                e = exp_q.pop_front();
                chk("beat_tdata", 64'(m_axis_data_tdata), 64'(e[DW+UW-1:UW]));
                chk("beat_tuser", 64'(m_axis_data_tuser), 64'(e[UW-1:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req(input logic [AW-1:0] a, input logic [UW-1:0] t);
        s_axis_req_tvalid = 1'b1;
        s_axis_req_tdata  = a;
        s_axis_req_tuser  = t;
    endtask

    task automatic ret(input logic [DW-1:0] d, input logic [UW-1:0] t);
        s_axis_rd_tvalid = 1'b1;
        s_axis_rd_tdata  = d;
        exp_q.push_back({d, t});
    endtask

    initial begin
        reset = 1'b1;
        s_axis_req_tvalid = 1'b0;
        s_axis_req_tdata  = '0;
        s_axis_req_tuser  = '0;
        m_axis_cmd_tready = 1'b1;
        s_axis_rd_tvalid  = 1'b0;
        s_axis_rd_tdata   = '0;
        #2;
        chk("rst_tready", 64'(s_axis_req_tready), 64'd1);
        chk("rst_cmd_tvalid", 64'(m_axis_cmd_tvalid), 64'd0);
        chk("rst_cmd_tdata", 64'(m_axis_cmd_tdata), 64'd0);
        chk("rst_data_tvalid", 64'(m_axis_data_tvalid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        cyc(); cyc();
        reset = 1'b0;

        // single request, return three cycles after the command
        req(20'h00100, 4'd3);
        sample();
        chk("t1_tready", 64'(s_axis_req_tready), 64'd1);
        cyc();
        s_axis_req_tvalid = 1'b0;
        sample();
        chk("t1_cmd_tvalid", 64'(m_axis_cmd_tvalid), 64'd1);
        chk("t1_cmd_tdata", 64'(m_axis_cmd_tdata), 64'h00100);
        cyc();
        sample();
        chk("t1_cmd_drained", 64'(m_axis_cmd_tvalid), 64'd0);
        cyc(); cyc();
        ret(32'hDEADBEEF, 4'd3);
        cyc();
        s_axis_rd_tvalid = 1'b0;
        sample();
        chk("t1_cnt", 64'(dut.cnt_q), 64'd0);
        cyc();

        // fill to MAX_OUTSTANDING, fifth request held
        for (int i = 0; i < 4; i++) begin
            req(20'h00200 + 20'(i), 4'(i));
            cyc();
        end
        req(20'h00300, 4'd4);
        sample();
        chk("t2_full_tready", 64'(s_axis_req_tready), 64'd0);
        cyc(); cyc();
        sample();
        chk("t2_held_tready", 64'(s_axis_req_tready), 64'd0);
        chk("t2_cmd_idle", 64'(m_axis_cmd_tvalid), 64'd0);
        ret(32'h000000A0, 4'd0);
        cyc();
        s_axis_rd_tvalid = 1'b0;
        sample();
        chk("t2_tready_back", 64'(s_axis_req_tready), 64'd1);
        cyc();
        s_axis_req_tvalid = 1'b0;
        sample();
        chk("t2_tag4_cmd", 64'(m_axis_cmd_tdata), 64'h00300);
        chk("t2_cnt_full", 64'(dut.cnt_q), 64'd4);
        cyc();
        for (int i = 1; i <= 4; i++) begin
            ret(32'h000000A0 + 32'(i), 4'(i));
            cyc();
        end
        s_axis_rd_tvalid = 1'b0;
        sample();
        chk("t2_cnt", 64'(dut.cnt_q), 64'd0);
        cyc();

        // command backpressure
        m_axis_cmd_tready = 1'b0;
        req(20'h00310, 4'd1);
        cyc();
        req(20'h00314, 4'd2);
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t3_cmd_hold", 64'(m_axis_cmd_tdata), 64'h00310);
            chk("t3_cmd_tvalid", 64'(m_axis_cmd_tvalid), 64'd1);
            chk("t3_stall_tready", 64'(s_axis_req_tready), 64'd0);
            cyc();
        end
        m_axis_cmd_tready = 1'b1;
        sample();
        chk("t3_release_tready", 64'(s_axis_req_tready), 64'd1);
        cyc();
        s_axis_req_tvalid = 1'b0;
        sample();
        chk("t3_reload_tvalid", 64'(m_axis_cmd_tvalid), 64'd1);
        chk("t3_reload_tdata", 64'(m_axis_cmd_tdata), 64'h00314);
        cyc();
        ret(32'h000000B1, 4'd1);
        cyc();
        ret(32'h000000B2, 4'd2);
        cyc();
        s_axis_rd_tvalid = 1'b0;
        cyc();

        // simultaneous accept and return keeps cnt
        req(20'h00400, 4'd5);
        cyc();
        req(20'h00404, 4'd6);
        cyc();
        s_axis_req_tvalid = 1'b0;
        cyc();
        req(20'h00408, 4'd7);
        ret(32'h000000C5, 4'd5);
        cyc();
        s_axis_req_tvalid = 1'b0;
        s_axis_rd_tvalid  = 1'b0;
        sample();
        chk("t4_cnt_same", 64'(dut.cnt_q), 64'd2);
        cyc();
        ret(32'h000000C6, 4'd6);
        cyc();
        ret(32'h000000C7, 4'd7);
        cyc();
        s_axis_rd_tvalid = 1'b0;
        sample();
        chk("t4_cnt", 64'(dut.cnt_q), 64'd0);
        cyc();

        // stray return with nothing in flight
        s_axis_rd_tvalid = 1'b1;
        s_axis_rd_tdata  = 32'h000000EE;
        cyc();
        s_axis_rd_tvalid = 1'b0;
        sample();
        chk("t5_err", 64'(err), 64'd1);
        chk("t5_no_beat", 64'(m_axis_data_tvalid), 64'd0);
        repeat (10) cyc();
        sample();
        chk("t5_err_sticky", 64'(err), 64'd1);
        cyc();

        // asynchronous reset with three outstanding
        for (int i = 1; i <= 3; i++) begin
            req(20'h00500 + 20'(i), 4'(i));
            cyc();
        end
        s_axis_req_tvalid = 1'b0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_tready", 64'(s_axis_req_tready), 64'd1);
        chk("t6_cmd_tvalid", 64'(m_axis_cmd_tvalid), 64'd0);
        chk("t6_cmd_tdata", 64'(m_axis_cmd_tdata), 64'd0);
        chk("t6_data_tvalid", 64'(m_axis_data_tvalid), 64'd0);
        chk("t6_data_tdata", 64'(m_axis_data_tdata), 64'd0);
        chk("t6_data_tuser", 64'(m_axis_data_tuser), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        chk("t6_cnt", 64'(dut.cnt_q), 64'd0);
        cyc();
        reset = 1'b0;
        cyc();
        req(20'h00900, 4'd9);
        cyc();
        s_axis_req_tvalid = 1'b0;
        cyc();
        ret(32'h12345678, 4'd9);
        cyc();
        s_axis_rd_tvalid = 1'b0;
        repeat (3) cyc();

        chk("all_beats_seen", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu86_icache_lane.md
# cpu86_icache_lane

Instruction-cache fetch lane: the producer side of the icache reorder buffer's tagged-return interface. Accepts tagged fetch requests, issues address commands to one memory port, and holds tags in order while reads are in flight. Pairs each returned word with its tag and emits it as a single-cycle `tvalid`/`tdata`/`tuser` beat on a channel with no backpressure. S_QTY instances of this lane feed the reorder buffer's `s_axis_data_*` inputs.

## Interface
- TDATA_WIDTH, 32, returned instruction word width
- TUSER_WIDTH, 4, reorder tag width
- ADDR_WIDTH, 20, fetch address width
- MAX_OUTSTANDING, 4, in-flight request limit; power of two, ≥2
- clk  in  1  clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- s_axis_req_tvalid  in  1  fetch request valid
- s_axis_req_tready  out  1  fetch request ready
- s_axis_req_tdata  in  ADDR_WIDTH  fetch address
- s_axis_req_tuser  in  TUSER_WIDTH  reorder tag
- m_axis_cmd_tvalid  out  1  memory read command valid
- m_axis_cmd_tready  in  1  memory read command ready
- m_axis_cmd_tdata  out  ADDR_WIDTH  memory read address
- s_axis_rd_tvalid  in  1  memory read data valid; returned in command order, no ready
- s_axis_rd_tdata  in  TDATA_WIDTH  memory read data
- m_axis_data_tvalid  out  1  tagged result valid; one-cycle pulse, no ready
- m_axis_data_tdata  out  TDATA_WIDTH  result word
- m_axis_data_tuser  out  TUSER_WIDTH  result tag
- err  out  1  sticky protocol error

## Operation
- Outstanding counter `cnt` has width clog2(MAX_OUTSTANDING)+1.
  - It counts requests accepted but not yet returned, including a command still held in the command register.
  - +1 on accept, −1 on `s_axis_rd_tvalid` when cnt≠0. Both in the same cycle leave it unchanged.
- `s_axis_req_tready` = (~m_axis_cmd_tvalid | m_axis_cmd_tready) & (cnt ≠ MAX_OUTSTANDING). It is combinational from registered state plus `m_axis_cmd_tready`.
- On accept:
  - The address loads into the command register and `m_axis_cmd_tvalid` is set.
  - The tag pushes into the tag FIFO (depth MAX_OUTSTANDING, pointers wrap modulo depth).
- Command register:
  - Holds address and valid stable until `m_axis_cmd_tready`.
  - Clears when `tready` is high and there is no new accept in that cycle.
  - Accept and drain in the same cycle reloads it; `tvalid` stays high.
- Read return with cnt≠0:
  - The FIFO head tag pops.
  - The next cycle `m_axis_data_tvalid`=1, `tdata`=returned word, `tuser`=popped tag.
  - Otherwise `m_axis_data_tvalid`=0; `tdata`/`tuser` hold their last values.
- Push and pop in the same cycle are legal at any occupancy below full. The FIFO never overflows because `tready` gates on cnt.
- Read return with cnt=0: ignored. No pop, no output, `err` set to 1 and held until reset.
- Return order equals accept order. Tags pass through unmodified; the block does not check tag uniqueness.

## Timing
- Reset values: `s_axis_req_tready`=1, `m_axis_cmd_tvalid`=0, `m_axis_cmd_tdata`=0, `m_axis_data_tvalid`=0, `m_axis_data_tdata`=0, `m_axis_data_tuser`=0, `err`=0, cnt=0, FIFO pointers=0.
- Reset is asynchronous: outputs reach reset values without a clock edge. In-flight requests are discarded; the memory side is reset together with the lane.
- Accept at edge N → `m_axis_cmd_tvalid` high from cycle N+1.
- Read data at edge M → `m_axis_data_tvalid` high for exactly cycle M+1.
- Throughput is one request and one return per cycle sustained.
- When cnt drops from MAX_OUTSTANDING, `tready` rises in the cycle after the return edge.

## Test plan
- Request addr 0x00100, tag 3, `cmd_tready`=1 → `m_axis_cmd_tdata`=0x00100 for one cycle. Memory returns 0xDEADBEEF three cycles later → one-cycle `m_axis_data_tvalid` with `tdata`=0xDEADBEEF, `tuser`=3, cnt back to 0.
- Four back-to-back requests, tags 0,1,2,3, no returns:
  - `s_axis_req_tready`=0 after the 4th accept; a 5th request (tag 4) is held.
  - One return → output `tuser`=0, `tready`=1 the next cycle, tag 4 accepted.
- `m_axis_cmd_tready` held 0 for 5 cycles after the first accept → command address stable, second request stalled with `tready`=0. Release → second request accepted in the same cycle the first drains.
- cnt=2 (tags 5,6 in flight), new request tag 7 accepted in the same cycle a return arrives → cnt stays 2, outputs `tuser` 5 then 6 then 7 in order.
- `s_axis_rd_tvalid` pulsed with cnt=0 → no `m_axis_data_tvalid`, `err`=1 and still 1 ten cycles later; reset clears it.
- Reset asserted mid-cycle with 3 outstanding → all outputs at reset values before the next edge. After release, request tag 9 with return 0x12345678 → output `tuser`=9, `tdata`=0x12345678.
